// File: rtl/mat_pkg.sv
// Shared definitions for the matrix-vector multiply-accumulate block:
// default element width, the frame state encoding and the accumulator
// width derivation used by both the top level and the MAC unit.
package mat_pkg;

    localparam int DATA_W_DEFAULT = 8;

    // LOAD_VEC captures the input vector; MAC_ROW streams the matrix rows.
    typedef enum logic {
        LOAD_VEC = 1'b0,
        MAC_ROW  = 1'b1
    } state_t;

    // A full-scale product needs 2*data_w bits; summing `width` of them
    // adds clog2(width) carry bits, so the dot product can never wrap.
    function automatic int acc_width(input int data_w, input int width);
        return 2 * data_w + $clog2(width);
    endfunction

endpackage

// File: rtl/mat_mac_acc.sv
// Single unsigned multiply-accumulate unit. `sum` is the running total
// including the current product; the owner decides whether to keep it
// (enable), start the next row from zero (enable with restart) or drop
// everything (clear).
module mat_mac_acc
    import mat_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ACC_W  = acc_width(DATA_W_DEFAULT, 3)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic              restart,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  sum
);

    logic [ACC_W-1:0]    acc;
    logic [2*DATA_W-1:0] product;

    // Operands widened first so the product keeps all 2*DATA_W bits.
    assign product = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    assign sum     = acc + ACC_W'(product);

    // Accumulator register: cleared on reset/clear, restarted after a row's last beat.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments in clocked blocks so every register
        // samples pre-edge values regardless of block evaluation order.
        if (rst || clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= restart ? '0 : sum;
        end
    end

endmodule

// File: rtl/mat_vec_mac.sv
// Matrix-vector product y = A*x over a byte stream. The first WIDTH beats
// load x, the following WIDTH*HEIGHT beats are A in row-major order. One
// dot product per row leaves through a single-entry valid/ready register.
module mat_vec_mac
    import mat_pkg::*;
#(
    parameter  int WIDTH  = 3,
    parameter  int HEIGHT = 3,
    parameter  int DATA_W = DATA_W_DEFAULT,
    localparam int ACC_W  = acc_width(DATA_W, WIDTH),
    localparam int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [ROW_W-1:0]  out_row,
    output logic              out_last,
    output logic              busy
);

    localparam int               COL_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    state_t            state;
    state_t            state_next;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [DATA_W-1:0] vec [WIDTH];
    logic [DATA_W-1:0] vec_sel;
    logic [ACC_W-1:0]  sum;

    logic accept;
    logic col_at_last;
    logic row_at_last;
    logic vec_write;
    logic acc_clear;
    logic acc_enable;
    logic load_result;

    assign col_at_last = (col == COL_LAST);
    assign row_at_last = (row == ROW_LAST);
    assign accept      = in_valid && in_ready;
    assign vec_sel     = vec[col];
    assign busy        = !((state == LOAD_VEC) && (col == '0));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD_VEC;
        end else begin
            state <= state_next;
        end
    end

    // Next state, input handshake and datapath strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_next  = state;
        in_ready    = 1'b0;
        vec_write   = 1'b0;
        acc_clear   = 1'b0;
        acc_enable  = 1'b0;
        load_result = 1'b0;

        if (!rst) begin
            case (state)
                LOAD_VEC: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        vec_write = 1'b1;
                        if (col_at_last) begin
                            acc_clear  = 1'b1;
                            state_next = MAC_ROW;
                        end
                    end
                end
                MAC_ROW: begin
                    // The row-closing beat needs the output register free,
                    // or being emptied by downstream in this same cycle.
                    in_ready = col_at_last ? (!out_valid || out_ready) : 1'b1;
                    if (in_valid && in_ready) begin
                        acc_enable = 1'b1;
                        if (col_at_last) begin
                            load_result = 1'b1;
                            if (row_at_last) begin
                                state_next = LOAD_VEC;
                            end
                        end
                    end
                end
                default: state_next = LOAD_VEC;
            endcase
        end
    end

    // Column and row counters, advanced on accepted beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else begin
            if (accept) begin
                col <= col_at_last ? '0 : col + COL_W'(1);
            end
            if (load_result) begin
                row <= row_at_last ? '0 : row + ROW_W'(1);
            end
        end
    end

    // Stored input vector.
    always_ff @(posedge clk) begin
        // NOTE: this small register array is reset explicitly so a frame that
        // starts after reset never multiplies against stale data; larger RAMs
        // would not get a reset port.
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                vec[i] <= '0;
            end
        end else if (vec_write) begin
            vec[col] <= in_data;
        end
    end

    mat_mac_acc #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .clear   (acc_clear),
        .enable  (acc_enable),
        .restart (col_at_last),
        .a       (in_data),
        .b       (vec_sel),
        .sum     (sum)
    );

    // Output register: loads a finished row, holds it until downstream takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_last  <= 1'b0;
        end else if (load_result) begin
            out_valid <= 1'b1;
            out_data  <= sum;
            out_row   <= row;
            out_last  <= row_at_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
